gauss_conv_sequencer: RTL
=========================

# gauss_conv_sequencer

Raster-order scheduler for the KSIZE×KSIZE Gaussian convolution MAC datapath. On a start pulse it walks every output pixel of a ROWS×COLS frame. For each pixel it issues one tap request per kernel coefficient: source pixel coordinates and flat address, coefficient index, an in-bounds flag and an end-of-pixel marker. The MAC accumulates in-bounds taps and writes the result on the last tap. The block sits between the frame memory/MAC pair and the host control registers.

## Interface
- ROWS, 192, frame height in pixels
- COLS, 192, frame width in pixels
- KSIZE, 5, kernel order; odd, 3..7
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame start request
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the final tap is accepted
- tap_valid  out  1  tap request valid
- tap_ready  in  1  MAC accepts the tap
- tap_row  out  $clog2(ROWS)  source row; 0 when tap_inb=0
- tap_col  out  $clog2(COLS)  source column; 0 when tap_inb=0
- tap_addr  out  $clog2(ROWS*COLS)  tap_row*COLS+tap_col
- tap_coef  out  $clog2(KSIZE*KSIZE)  coefficient index ky*KSIZE+kx
- tap_inb  out  1  source inside the frame
- tap_last  out  1  final tap of the current output pixel
- out_row  out  $clog2(ROWS)  output pixel row being computed
- out_col  out  $clog2(COLS)  output pixel column being computed

## Operation
- Let c = KSIZE/2.
- Source coordinates are r = out_row+ky-c and s = out_col+kx-c.
- tap_inb = (0 ≤ r < ROWS) && (0 ≤ s < COLS). Compute the sign with one extra bit of width.
- Taps are issued in order ky 0..KSIZE-1 (outer) and kx 0..KSIZE-1 (inner).
- Output pixels are visited in raster order: row 0 first, and col increments fastest.
- States and transitions:
  - IDLE: start → RUN.
  - RUN: after the last tap of pixel (ROWS-1, COLS-1) is accepted → DONE.
  - DONE: unconditionally → IDLE.
- A tap is accepted on tap_valid && tap_ready. Counters advance only on acceptance.
- While tap_valid is high and tap_ready is low, every tap_* and out_* output holds stable.
- start is ignored in RUN and DONE. It is not queued.
- tap_last rises once per output pixel.
- All outputs are registered.

## Timing
- Reset value of every output is 0. State resets to IDLE and all counters reset to 0.
- Start sampled in IDLE at cycle N:
  - busy and tap_valid are high at N+1.
  - The first tap is (0,0) with coefficient 0.
- Sustained throughput is one tap per cycle while tap_ready is held high.
- Without stalls, the last tap is presented at cycle N + ROWS·COLS·KSIZE² (or N + issued-tap count when skip mode is on).
- DONE is entered on the cycle after the last acceptance:
  - done=1, busy=1 and tap_valid=0 in that cycle.
  - The block returns to IDLE with busy=0 on the next cycle.
- tap_valid never drops between taps inside RUN.
- rst_n asserted mid-frame:
  - All outputs go to 0 immediately.
  - The frame is abandoned. There is no done pulse.
  - A new start is required after release.

## Configuration
- GAUSS_SKIP_OOB_EN defined:
  - Out-of-bounds taps are never issued, so tap_inb is always 1.
  - The ky/kx ranges are clipped per pixel to [max(0,c-out_row), min(KSIZE-1,ROWS-1-out_row+c)]. The column range is clipped the same way.
  - tap_last marks the last in-bounds tap.
  - tap_coef still reflects the true ky,kx.
- GAUSS_SKIP_OOB_EN undefined:
  - All KSIZE² taps are issued for every pixel.
  - Border taps carry tap_inb=0, and the MAC must ignore them.

## Structure
- Package gauss_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - KSIZE_MIN=3 and KSIZE_MAX=7;
  - coordinate and coefficient width helper functions.
- Elaboration asserts that KSIZE is odd and within range.
- Sub-module gauss_win_counter is a nested ky/kx counter with per-pixel lower and upper bounds and a wrap flag. It is instantiated once. The pixel row/col counter stays inline.

## Test plan
- ROWS=COLS=4, KSIZE=3, tap_ready=1, start at cycle 0:
  - 144 taps are issued and done pulses at cycle 145.
  - Pixel (0,0) shows the tap_inb sequence 0,0,0,0,1,1,0,1,1.
  - With GAUSS_SKIP_OOB_EN: 100 taps, done at cycle 101, and pixel (0,0) shows coefficients 4,5,7,8.
- Random tap_ready at 50% duty: outputs stay stable during stalls, and the tap sequence is identical to the no-stall run.
- Interior pixel (2,2), KSIZE=5, 8×8 frame:
  - tap_addr runs 0,1,2,3,4,8,…,36.
  - tap_last is high only on coefficient 24.
- start pulsed again during RUN and during DONE: ignored; exactly one done pulse per accepted start.
- rst_n low mid-frame for 1 cycle:
  - All outputs are 0 and there is no done pulse.
  - After start, the sequence restarts at pixel (0,0), coefficient 0.
- Corner pixel (ROWS-1, COLS-1) with KSIZE=7 on a 192×192 frame: the in-bounds count is 16, and tap_last falls on coefficient 48 (coefficient 24 in skip mode).

Source files
------------

// File: rtl/gauss_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gauss_pkg
//  Purpose  : Shared types and helpers for the Gaussian convolution sequencer:
//             the sequencer state enum, the legal kernel-order range and width
//             helper functions for coordinates and coefficient indices.
//  Revision : 1.0  initial release
// ============================================================================
package gauss_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int KSIZE_MIN = 3;
    localparam int KSIZE_MAX = 7;

    // Width needed to index n items; never below one bit.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a flat coefficient index ky*k+kx.
    function automatic int coef_w(input int k);
        return coord_w(k * k);
    endfunction

    // Width of a single kernel axis index (ky or kx).
    function automatic int win_w(input int k);
        return coord_w(k);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gauss_win_counter.sv
`default_nettype none
// ============================================================================
//  Module   : gauss_win_counter
//  Purpose  : Nested ky (outer) / kx (inner) kernel-window counter with
//             per-pixel bounds. kx wraps back to kx_lo and ky increments when
//             kx reaches kx_hi. load reseeds both axes for a new pixel.
//  Ports    : clk, rst_n          clock, asynchronous active-low reset
//             load, load_ky/kx    reseed for the next pixel (priority)
//             step                advance one tap inside the current pixel
//             ky_hi, kx_lo, kx_hi bounds of the current pixel
//             ky, kx              current window position
//             ky_nxt, kx_nxt      position after this cycle's load/step
//             wrap                current position is the pixel's last tap
//  Revision : 1.0  initial release
// ============================================================================
module gauss_win_counter
    import gauss_pkg::*;
#(
    parameter int KSIZE = 5,
    parameter int KW    = win_w(KSIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [KW-1:0] load_ky,
    input  logic [KW-1:0] load_kx,
    input  logic          step,
    input  logic [KW-1:0] ky_hi,
    input  logic [KW-1:0] kx_lo,
    input  logic [KW-1:0] kx_hi,
    output logic [KW-1:0] ky,
    output logic [KW-1:0] kx,
    output logic [KW-1:0] ky_nxt,
    output logic [KW-1:0] kx_nxt,
    output logic          wrap
);

    logic [KW-1:0] r_ky;
    logic [KW-1:0] r_kx;

    // The top never steps on the wrap tap (it loads instead), so ky cannot
    // run past ky_hi here.
    always_comb begin
        ky_nxt = r_ky;
        kx_nxt = r_kx;
        if (load) begin
            ky_nxt = load_ky;
            kx_nxt = load_kx;
        end else if (step) begin
            if (r_kx == kx_hi) begin
                kx_nxt = kx_lo;
                ky_nxt = r_ky + KW'(1);
            end else begin
                kx_nxt = r_kx + KW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ky <= '0;
            r_kx <= '0;
        end else begin
            r_ky <= ky_nxt;
            r_kx <= kx_nxt;
        end
    end

    assign ky   = r_ky;
    assign kx   = r_kx;
    assign wrap = (r_ky == ky_hi) && (r_kx == kx_hi);

endmodule
`default_nettype wire

// File: rtl/gauss_conv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : gauss_conv_sequencer
//  Purpose  : Raster-order tap scheduler for a KSIZE x KSIZE Gaussian MAC.
//             For every output pixel of a ROWS x COLS frame it issues one tap
//             per kernel coefficient (ky outer, kx inner) with source
//             coordinates, flat address, coefficient index, in-bounds flag
//             and end-of-pixel marker. Taps advance on tap_valid & tap_ready.
//  Ports    : clk, rst_n        clock, asynchronous active-low reset
//             start             frame start (honoured in IDLE only)
//             busy, done        frame in progress / one-cycle completion
//             tap_valid/ready   tap handshake
//             tap_row/col/addr  source pixel (zero when out of bounds)
//             tap_coef          ky*KSIZE+kx
//             tap_inb, tap_last in-bounds flag, last tap of the pixel
//             out_row/col       output pixel being computed
//  Config   : GAUSS_SKIP_OOB_EN  when defined, out-of-bounds taps are not
//             issued; the window is clipped per pixel to the frame.
//  Revision : 1.0  initial release
// ============================================================================
module gauss_conv_sequencer
    import gauss_pkg::*;
#(
    parameter int ROWS  = 192,
    parameter int COLS  = 192,
    parameter int KSIZE = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           tap_valid,
    input  logic                           tap_ready,
    output logic [coord_w(ROWS)-1:0]       tap_row,
    output logic [coord_w(COLS)-1:0]       tap_col,
    output logic [coord_w(ROWS*COLS)-1:0]  tap_addr,
    output logic [coef_w(KSIZE)-1:0]       tap_coef,
    output logic                           tap_inb,
    output logic                           tap_last,
    output logic [coord_w(ROWS)-1:0]       out_row,
    output logic [coord_w(COLS)-1:0]       out_col
);

    localparam int c_rw   = coord_w(ROWS);
    localparam int c_cw   = coord_w(COLS);
    localparam int c_aw   = coord_w(ROWS * COLS);
    localparam int c_kcw  = coef_w(KSIZE);
    localparam int c_kw   = win_w(KSIZE);
    localparam int c_half = KSIZE / 2;

`ifdef GAUSS_SKIP_OOB_EN
    localparam bit c_skip = 1'b1;
`else
    localparam bit c_skip = 1'b0;
`endif

    if ((KSIZE % 2) == 0 || KSIZE < KSIZE_MIN || KSIZE > KSIZE_MAX) begin : g_ksize_bad
        $error("gauss_conv_sequencer: KSIZE must be odd and within 3..7");
    end

    // Window bounds for pixel coordinate p on an axis of length n. Without
    // skipping, the whole kernel is walked and borders are flagged instead.
    function automatic logic [c_kw-1:0] lo_bound(input int p);
        if (c_skip && p < c_half)
            return c_kw'(c_half - p);
        return '0;
    endfunction

    function automatic logic [c_kw-1:0] hi_bound(input int p, input int n);
        if (c_skip && (p + c_half > n - 1))
            return c_kw'(n - 1 - p + c_half);
        return c_kw'(KSIZE - 1);
    endfunction

    state_t            r_state;

    logic              w_accept;
    logic              w_wrap;
    logic              w_frame_last;
    logic              w_step_pix;
    logic              w_load;
    logic              w_step;
    logic              w_upd;
    logic [c_rw-1:0]   w_nrow;
    logic [c_cw-1:0]   w_ncol;
    logic [c_kw-1:0]   w_cky_hi, w_ckx_lo, w_ckx_hi;
    logic [c_kw-1:0]   w_nky_lo, w_nky_hi, w_nkx_lo, w_nkx_hi;
    logic [c_kw-1:0]   w_ky, w_kx, w_ky_nxt, w_kx_nxt;
    int                w_sr, w_sc;
    logic              w_inb;
    logic [c_rw-1:0]   w_trow;
    logic [c_cw-1:0]   w_tcol;
    logic [c_aw-1:0]   w_taddr;
    logic [c_kcw-1:0]  w_tcoef;
    logic              w_tlast;

    // Pixel stepping: out_row/out_col double as the raster counters.
    always_comb begin
        w_accept     = (r_state == RUN) && tap_valid && tap_ready;
        w_frame_last = w_wrap && (out_row == c_rw'(ROWS - 1)) && (out_col == c_cw'(COLS - 1));
        w_step_pix   = w_accept && w_wrap && !w_frame_last;
        w_load       = ((r_state == IDLE) && start) || w_step_pix;
        w_step       = w_accept && !w_wrap;
        w_upd        = w_load || w_step;
        w_nrow       = out_row;
        w_ncol       = out_col;
        if (r_state == IDLE) begin
            w_nrow = '0;
            w_ncol = '0;
        end else if (w_step_pix) begin
            if (out_col == c_cw'(COLS - 1)) begin
                w_ncol = '0;
                w_nrow = out_row + c_rw'(1);
            end else begin
                w_ncol = out_col + c_cw'(1);
            end
        end
    end

    always_comb begin
        w_cky_hi = hi_bound(int'(out_row), ROWS);
        w_ckx_lo = lo_bound(int'(out_col));
        w_ckx_hi = hi_bound(int'(out_col), COLS);
        w_nky_lo = lo_bound(int'(w_nrow));
        w_nky_hi = hi_bound(int'(w_nrow), ROWS);
        w_nkx_lo = lo_bound(int'(w_ncol));
        w_nkx_hi = hi_bound(int'(w_ncol), COLS);
    end

    gauss_win_counter #(
        .KSIZE (KSIZE),
        .KW    (c_kw)
    ) u_win (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_load),
        .load_ky (w_nky_lo),
        .load_kx (w_nkx_lo),
        .step    (w_step),
        .ky_hi   (w_cky_hi),
        .kx_lo   (w_ckx_lo),
        .kx_hi   (w_ckx_hi),
        .ky      (w_ky),
        .kx      (w_kx),
        .ky_nxt  (w_ky_nxt),
        .kx_nxt  (w_kx_nxt),
        .wrap    (w_wrap)
    );

    // Tap about to be presented. Signed int arithmetic keeps the sign of
    // sources that fall above/left of the frame.
    always_comb begin
        w_sr    = int'(w_nrow) + int'(w_ky_nxt) - c_half;
        w_sc    = int'(w_ncol) + int'(w_kx_nxt) - c_half;
        w_inb   = (w_sr >= 0) && (w_sr < ROWS) && (w_sc >= 0) && (w_sc < COLS);
        w_trow  = w_inb ? c_rw'(w_sr) : '0;
        w_tcol  = w_inb ? c_cw'(w_sc) : '0;
        w_taddr = w_inb ? c_aw'(w_sr * COLS + w_sc) : '0;
        w_tcoef = c_kcw'(int'(w_ky_nxt) * KSIZE + int'(w_kx_nxt));
        w_tlast = (w_ky_nxt == w_nky_hi) && (w_kx_nxt == w_nkx_hi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            tap_valid <= 1'b0;
            tap_row   <= '0;
            tap_col   <= '0;
            tap_addr  <= '0;
            tap_coef  <= '0;
            tap_inb   <= 1'b0;
            tap_last  <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= RUN;
                        busy      <= 1'b1;
                        tap_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_accept && w_frame_last) begin
                        r_state   <= DONE;
                        tap_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase

            if (w_upd) begin
                out_row  <= w_nrow;
                out_col  <= w_ncol;
                tap_row  <= w_trow;
                tap_col  <= w_tcol;
                tap_addr <= w_taddr;
                tap_coef <= w_tcoef;
                tap_inb  <= w_inb;
                tap_last <= w_tlast;
            end
        end
    end

endmodule
`default_nettype wire
